// File: rtl/seq6_code_tracker.sv
// ---------------------------------------------------------------------------
// seq6_code_tracker
//
// Receive-side checker for the 6-state 3-bit code counter
//   000 -> 011 -> 001 -> 111 -> 110 -> 100 -> 000
// Each sampled code is decoded to an index 0..5 and checked against the
// legal successor of the previous sample. The checker hunts for a legal
// code, synchronises over LOCK_CNT good transitions, then holds lock until
// UNLOCK_CNT consecutive bad samples arrive. Sequence errors seen while
// locked are counted in a saturating counter.
//
// Handshake: code_valid is a one-way strobe with no back-pressure. A cycle
// with code_valid=1 delivers exactly one sample; code_valid=0 is an idle
// cycle that changes nothing. Every output is registered and reflects the
// sample taken on the same rising edge.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-low
//   code_in      in   3      code under test
//   code_valid   in   1      sample strobe
//   index        out  3      decoded index of last legal sample
//   index_valid  out  1      pulse: index updated
//   locked       out  1      1 while in LOCKED
//   seq_err      out  1      pulse: bad sample while LOCKED
//   illegal      out  1      pulse: sampled code is 010 or 101
//   wrap         out  1      pulse: good 100->000 transition while LOCKED
//   err_count    out  ERR_W  saturating count of seq_err pulses
//   fsm_state    out  2      debug view of the FSM state register
// ---------------------------------------------------------------------------
module seq6_code_tracker #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic [2:0]       index,
  output logic             index_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             illegal,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fsm_state
);

  localparam int GW = (LOCK_CNT   < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int BW = (UNLOCK_CNT < 1) ? 1 : $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Successor in the code cycle. Illegal codes never reach this as prev.
  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      3'b000:  succ = 3'b011;
      3'b011:  succ = 3'b001;
      3'b001:  succ = 3'b111;
      3'b111:  succ = 3'b110;
      3'b110:  succ = 3'b100;
      3'b100:  succ = 3'b000;
      default: succ = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] decode(input logic [2:0] c);
    case (c)
      3'b000:  decode = 3'd0;
      3'b011:  decode = 3'd1;
      3'b001:  decode = 3'd2;
      3'b111:  decode = 3'd3;
      3'b110:  decode = 3'd4;
      3'b100:  decode = 3'd5;
      default: decode = 3'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] c);
    is_legal = (c != 3'b010) && (c != 3'b101);
  endfunction

  state_t            state, state_n;
  logic [2:0]        prev, prev_n;
  logic              prev_vld, prev_vld_n;
  logic [GW-1:0]     good_cnt, good_cnt_n;
  logic [BW-1:0]     bad_cnt, bad_cnt_n;
  logic [2:0]        index_n;
  logic              index_valid_n, seq_err_n, illegal_n, wrap_n, locked_n;
  logic [ERR_W-1:0]  err_count_n;

  logic              legal;
  logic              good;
  logic [GW-1:0]     good_inc;
  logic [BW-1:0]     bad_inc;

  assign fsm_state = state;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_n       = state;
    prev_n        = prev;
    prev_vld_n    = prev_vld;
    good_cnt_n    = good_cnt;
    bad_cnt_n     = bad_cnt;
    index_n       = index;
    index_valid_n = 1'b0;
    seq_err_n     = 1'b0;
    illegal_n     = 1'b0;
    wrap_n        = 1'b0;
    err_count_n   = err_count;

    legal    = is_legal(code_in);
    // A repeated code is never its own successor, so it falls out as bad.
    good     = prev_vld && legal && (code_in == succ(prev));
    good_inc = good_cnt + GW'(1);
    bad_inc  = bad_cnt + BW'(1);

    if (code_valid) begin
      if (legal) begin
        index_n       = decode(code_in);
        index_valid_n = 1'b1;
      end else begin
        illegal_n = 1'b1;
      end

      case (state)
        S_HUNT: begin
          if (legal) begin
            prev_n     = code_in;
            prev_vld_n = 1'b1;
            good_cnt_n = '0;
            state_n    = S_SYNC;
          end
        end

        S_SYNC: begin
          if (!legal) begin
            prev_vld_n = 1'b0;
            state_n    = S_HUNT;
          end else begin
            prev_n = code_in;
            if (good) begin
              good_cnt_n = good_inc;
              if (good_inc == GW'(LOCK_CNT)) begin
                bad_cnt_n = '0;
                state_n   = S_LOCKED;
              end
            end else begin
              good_cnt_n = '0;
            end
          end
        end

        S_LOCKED: begin
          if (good) begin
            bad_cnt_n = '0;
            prev_n    = code_in;
            wrap_n    = (prev == 3'b100);
          end else begin
            seq_err_n = 1'b1;
            if (err_count != {ERR_W{1'b1}}) begin
              err_count_n = err_count + ERR_W'(1);
            end
            bad_cnt_n = bad_inc;
            // On an illegal code, flywheel: assume the expected code arrived
            // so a single corrupted sample does not cascade into a second error.
            prev_n = legal ? code_in : succ(prev);
            if (bad_inc == BW'(UNLOCK_CNT)) begin
              prev_vld_n = 1'b0;
              state_n    = S_HUNT;
            end
          end
        end

        default: begin
          prev_vld_n = 1'b0;
          state_n    = S_HUNT;
        end
      endcase
    end

    locked_n = (state_n == S_LOCKED);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_HUNT;
      prev        <= 3'b000;
      prev_vld    <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      index       <= 3'd0;
      index_valid <= 1'b0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      illegal     <= 1'b0;
      wrap        <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      prev_vld    <= prev_vld_n;
      good_cnt    <= good_cnt_n;
      bad_cnt     <= bad_cnt_n;
      index       <= index_n;
      index_valid <= index_valid_n;
      locked      <= locked_n;
      seq_err     <= seq_err_n;
      illegal     <= illegal_n;
      wrap        <= wrap_n;
      err_count   <= err_count_n;
    end
  end

endmodule
